// File: rtl/bus_master_if_pkg.sv
// bus_master_if_pkg
// Shared definitions for the bus master interface block: bus word widths,
// read/write encoding, active-low enable levels and the FSM state encoding.
package bus_master_if_pkg;

    localparam int WORD_ADDR_W = 30;
    localparam int WORD_DATA_W = 32;

    typedef logic [WORD_ADDR_W-1:0] word_addr_t;
    typedef logic [WORD_DATA_W-1:0] word_data_t;

    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    // Levels for the active-low bus control signals
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ADDR = 2'd2,
        WAIT = 2'd3
    } state_e;

endpackage

// File: rtl/bus_master_if_if.sv
// bus_master_if_if
// Signals between one master port of the shared bus and the interconnect.
//   bus_req_     master -> arbiter   bus request, active-low
//   bus_grnt_    arbiter -> master   bus grant, active-low
//   bus_addr     master -> mux       word address
//   bus_as_      master -> mux       address strobe, active-low
//   bus_rw       master -> mux       1=read, 0=write
//   bus_wr_data  master -> mux       write data
//   bus_rd_data  shared -> master    read data (shared by all masters)
//   bus_rdy_     shared -> master    slave ready, active-low (shared)
interface bus_master_if_if;
    import bus_master_if_pkg::*;

    logic       bus_req_;
    logic       bus_grnt_;
    word_addr_t bus_addr;
    logic       bus_as_;
    logic       bus_rw;
    word_data_t bus_wr_data;
    word_data_t bus_rd_data;
    logic       bus_rdy_;

    modport master (
        output bus_req_, bus_addr, bus_as_, bus_rw, bus_wr_data,
        input  bus_grnt_, bus_rd_data, bus_rdy_
    );

    modport slave (
        input  bus_req_, bus_addr, bus_as_, bus_rw, bus_wr_data,
        output bus_grnt_, bus_rd_data, bus_rdy_
    );

endinterface

// File: rtl/bus_master_if.sv
// bus_master_if
// Turns a single-word core access into one bus-master transaction:
// request, wait for grant, one-cycle address strobe, wait for ready,
// capture read data, release the bus. A ready-timeout aborts transfers
// to a slave that never answers.
// Ports:
//   clk, reset       clock and synchronous active-high reset
//   core_req         access request, sampled only while idle
//   core_addr        word address
//   core_rw          1=read, 0=write
//   core_wr_data     write data
//   core_busy        transaction in flight (combinational)
//   core_ack         one-cycle completion pulse
//   core_err         with core_ack: 1 = timeout abort
//   core_rd_data     read data, valid with core_ack, held until next ack
//   bus              master modport of the bus-side interface
module bus_master_if
    import bus_master_if_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int          CNT_W   = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            core_req,
    input  word_addr_t      core_addr,
    input  logic            core_rw,
    input  word_data_t      core_wr_data,
    output logic            core_busy,
    output logic            core_ack,
    output logic            core_err,
    output word_data_t      core_rd_data,
    bus_master_if_if.master bus
);

    // Counter value at which a still-unanswered WAIT cycle aborts
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bus_req_q, bus_req_d;
    logic             bus_as_q, bus_as_d;
    logic             bus_rw_q, bus_rw_d;
    word_addr_t       bus_addr_q, bus_addr_d;
    word_data_t       bus_wr_data_q, bus_wr_data_d;
    logic             core_ack_q, core_ack_d;
    logic             core_err_q, core_err_d;
    word_data_t       core_rd_data_q, core_rd_data_d;

    logic rdy_hit;
    logic timeout_hit;

    assign rdy_hit     = (bus.bus_rdy_ == ENABLE_);
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            bus_req_q      <= DISABLE_;
            bus_as_q       <= DISABLE_;
            bus_rw_q       <= READ;
            bus_addr_q     <= '0;
            bus_wr_data_q  <= '0;
            core_ack_q     <= 1'b0;
            core_err_q     <= 1'b0;
            core_rd_data_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            bus_req_q      <= bus_req_d;
            bus_as_q       <= bus_as_d;
            bus_rw_q       <= bus_rw_d;
            bus_addr_q     <= bus_addr_d;
            bus_wr_data_q  <= bus_wr_data_d;
            core_ack_q     <= core_ack_d;
            core_err_q     <= core_err_d;
            core_rd_data_q <= core_rd_data_d;
        end
    end

    // Next-state logic; ready in the same cycle as the timeout wins
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (core_req) state_d = REQ;
            REQ:  if (bus.bus_grnt_ == ENABLE_) state_d = ADDR;
            ADDR: state_d = rdy_hit ? IDLE : WAIT;
            WAIT: if (rdy_hit || timeout_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: values registered on the edge that leaves each state
    always_comb begin
        cnt_d          = cnt_q;
        bus_req_d      = bus_req_q;
        bus_as_d       = bus_as_q;
        bus_rw_d       = bus_rw_q;
        bus_addr_d     = bus_addr_q;
        bus_wr_data_d  = bus_wr_data_q;
        core_ack_d     = 1'b0;
        core_err_d     = 1'b0;
        core_rd_data_d = core_rd_data_q;
        case (state_q)
            IDLE: begin
                if (core_req) begin
                    bus_addr_d    = core_addr;
                    bus_rw_d      = core_rw;
                    bus_wr_data_d = core_wr_data;
                    bus_req_d     = ENABLE_;
                end
            end
            REQ: begin
                if (bus.bus_grnt_ == ENABLE_) begin
                    bus_as_d = ENABLE_;
                    cnt_d    = '0;
                end
            end
            ADDR, WAIT: begin
                cnt_d    = cnt_q + 1'b1;
                bus_as_d = DISABLE_;
                if (rdy_hit) begin
                    core_ack_d = 1'b1;
                    bus_req_d  = DISABLE_;
                    if (bus_rw_q == READ) core_rd_data_d = bus.bus_rd_data;
                end else if (state_q == WAIT && timeout_hit) begin
                    core_ack_d     = 1'b1;
                    core_err_d     = 1'b1;
                    core_rd_data_d = '0;
                    bus_req_d      = DISABLE_;
                end
            end
            default: ;
        endcase
    end

    assign core_busy       = (state_q != IDLE);
    assign core_ack        = core_ack_q;
    assign core_err        = core_err_q;
    assign core_rd_data    = core_rd_data_q;
    assign bus.bus_req_    = bus_req_q;
    assign bus.bus_as_     = bus_as_q;
    assign bus.bus_rw      = bus_rw_q;
    assign bus.bus_addr    = bus_addr_q;
    assign bus.bus_wr_data = bus_wr_data_q;

endmodule

// File: tb/tb_bus_master_if.sv
// tb_bus_master_if
// Self-checking bench for bus_master_if. Each transaction is described by
// its access fields, the number of grant-wait cycles and the number of
// slave wait states; the expected cycle-by-cycle bus and core behaviour is
// derived from those numbers alone.
module tb_bus_master_if;

    localparam int TIMEOUT = 4;

    typedef struct {
        logic        rw;
        logic [29:0] addr;
        logic [31:0] wd;
        int          g;
        int          w;
        logic [31:0] rd;
    } txn_t;

    logic        clk;
    logic        reset;
    logic        core_req;
    logic [29:0] core_addr;
    logic        core_rw;
    logic [31:0] core_wr_data;
    logic        core_busy;
    logic        core_ack;
    logic        core_err;
    logic [31:0] core_rd_data;

    int          checks;
    int          errors;
    logic [31:0] expRd;

    bus_master_if_if bif ();

    bus_master_if #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .core_req     (core_req),
        .core_addr    (core_addr),
        .core_rw      (core_rw),
        .core_wr_data (core_wr_data),
        .core_busy    (core_busy),
        .core_ack     (core_ack),
        .core_err     (core_err),
        .core_rd_data (core_rd_data),
        .bus          (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: count it, report observed/expected on failure
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic driveCore(input txn_t t);
        core_req     = 1'b1;
        core_addr    = t.addr;
        core_rw      = t.rw;
        core_wr_data = t.wd;
    endtask

    function automatic txn_t makeTxn();
        txn_t t;
        t.rw   = 1'($urandom);
        t.addr = 30'($urandom);
        t.wd   = $urandom;
        t.g    = int'($urandom_range(0, 3));
        t.w    = int'($urandom_range(0, 5));
        t.rd   = $urandom;
        return t;
    endfunction

    // Runs one transaction whose request is already on the core inputs, with
    // the DUT idle at the current negedge (cycle 0). Cycle n is the negedge
    // after n rising edges. With chain set, the next request is presented in
    // the ack cycle and the task returns there.
    task automatic applyStimulus(input txn_t t, input bit chain, input txn_t nxt);
        bit err;
        int ackN;
        int strobeN;
        err     = (t.w >= TIMEOUT);
        strobeN = 2 + t.g;
        ackN    = err ? strobeN + TIMEOUT : strobeN + 1 + t.w;
        for (int n = 0; n <= ackN; n++) begin
            checkOutput("bus_req_", {31'd0, bif.bus_req_}, (n >= 1 && n < ackN) ? 32'd0 : 32'd1);
            checkOutput("bus_as_", {31'd0, bif.bus_as_}, (n == strobeN) ? 32'd0 : 32'd1);
            checkOutput("core_busy", {31'd0, core_busy}, (n >= 1 && n < ackN) ? 32'd1 : 32'd0);
            if (n >= 1) begin
                checkOutput("core_ack", {31'd0, core_ack}, (n == ackN) ? 32'd1 : 32'd0);
                checkOutput("bus_addr", {2'd0, bif.bus_addr}, {2'd0, t.addr});
                checkOutput("bus_rw", {31'd0, bif.bus_rw}, {31'd0, t.rw});
                checkOutput("bus_wr_data", bif.bus_wr_data, t.wd);
            end
            if (n == ackN) begin
                if (err) expRd = 32'd0;
                else if (t.rw) expRd = t.rd;
                checkOutput("core_err", {31'd0, core_err}, {31'd0, err});
            end
            checkOutput("core_rd_data", core_rd_data, expRd);

            if (n == ackN) begin
                bif.bus_grnt_ = 1'b1;
                bif.bus_rdy_  = 1'b1;
                if (chain) driveCore(nxt);
                else core_req = 1'b0;
            end else begin
                if (n >= 1) begin
                    core_req     = ($urandom_range(0, 3) == 0);
                    core_addr    = 30'($urandom);
                    core_rw      = 1'($urandom);
                    core_wr_data = $urandom;
                end
                bif.bus_grnt_ = (n >= 1 + t.g) ? 1'b0 : 1'b1;
                if (n == strobeN + t.w) begin
                    bif.bus_rdy_    = 1'b0;
                    bif.bus_rd_data = t.rd;
                end else if (n < strobeN) begin
                    bif.bus_rdy_    = 1'($urandom);
                    bif.bus_rd_data = $urandom;
                end else begin
                    bif.bus_rdy_    = 1'b1;
                    bif.bus_rd_data = $urandom;
                end
                @(negedge clk);
            end
        end
        if (!chain) begin
            @(negedge clk);
            checkOutput("idle_bus_req_", {31'd0, bif.bus_req_}, 32'd1);
            checkOutput("idle_core_ack", {31'd0, core_ack}, 32'd0);
            checkOutput("idle_core_busy", {31'd0, core_busy}, 32'd0);
        end
    endtask

    txn_t t0, t1, none;
    txn_t rq[24];
    bit   rchain[24];

    initial begin
        checks        = 0;
        errors        = 0;
        expRd         = 32'd0;
        reset         = 1'b1;
        core_req      = 1'b0;
        core_addr     = '0;
        core_rw       = 1'b0;
        core_wr_data  = '0;
        bif.bus_grnt_ = 1'b1;
        bif.bus_rdy_  = 1'b1;
        bif.bus_rd_data = '0;
        none = '{rw: 1'b0, addr: 30'd0, wd: 32'd0, g: 0, w: 0, rd: 32'd0};

        // Reset values
        repeat (2) @(negedge clk);
        checkOutput("rst_bus_req_", {31'd0, bif.bus_req_}, 32'd1);
        checkOutput("rst_bus_as_", {31'd0, bif.bus_as_}, 32'd1);
        checkOutput("rst_bus_rw", {31'd0, bif.bus_rw}, 32'd1);
        checkOutput("rst_bus_addr", {2'd0, bif.bus_addr}, 32'd0);
        checkOutput("rst_bus_wr_data", bif.bus_wr_data, 32'd0);
        checkOutput("rst_core_ack", {31'd0, core_ack}, 32'd0);
        checkOutput("rst_core_err", {31'd0, core_err}, 32'd0);
        checkOutput("rst_core_rd_data", core_rd_data, 32'd0);
        checkOutput("rst_core_busy", {31'd0, core_busy}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Read, immediate grant, ready in the strobe cycle
        t0 = '{rw: 1'b1, addr: 30'h0000100, wd: 32'h0, g: 0, w: 0, rd: 32'hDEADBEEF};
        driveCore(t0);
        applyStimulus(t0, 1'b0, none);

        // Write with 3 wait states; ready lands on the last pre-timeout cycle
        t0 = '{rw: 1'b0, addr: 30'h2000004, wd: 32'h12345678, g: 0, w: 3, rd: 32'hA5A5A5A5};
        driveCore(t0);
        applyStimulus(t0, 1'b0, none);

        // Grant withheld for 5 cycles
        t0 = '{rw: 1'b1, addr: 30'h0ABCDEF, wd: 32'h0, g: 5, w: 0, rd: 32'h0BADF00D};
        driveCore(t0);
        applyStimulus(t0, 1'b0, none);

        // Slave never ready: timeout abort
        t0 = '{rw: 1'b1, addr: 30'h1234567, wd: 32'h0, g: 0, w: 1000, rd: 32'h0};
        driveCore(t0);
        applyStimulus(t0, 1'b0, none);

        // Reset in WAIT abandons the transfer without an ack
        t0 = '{rw: 1'b1, addr: 30'h0000040, wd: 32'h0, g: 0, w: 0, rd: 32'h0};
        driveCore(t0);
        @(negedge clk);
        core_req      = 1'b0;
        bif.bus_grnt_ = 1'b0;
        @(negedge clk);
        bif.bus_rdy_  = 1'b1;
        @(negedge clk);
        checkOutput("pre_rst_busy", {31'd0, core_busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset         = 1'b0;
        bif.bus_grnt_ = 1'b1;
        expRd         = 32'd0;
        checkOutput("midrst_bus_req_", {31'd0, bif.bus_req_}, 32'd1);
        checkOutput("midrst_bus_as_", {31'd0, bif.bus_as_}, 32'd1);
        checkOutput("midrst_core_busy", {31'd0, core_busy}, 32'd0);
        checkOutput("midrst_core_ack", {31'd0, core_ack}, 32'd0);
        @(negedge clk);
        checkOutput("postrst_core_ack", {31'd0, core_ack}, 32'd0);
        t0 = '{rw: 1'b1, addr: 30'h0000044, wd: 32'h0, g: 1, w: 1, rd: 32'hCAFEF00D};
        driveCore(t0);
        applyStimulus(t0, 1'b0, none);

        // Two reads back-to-back with core_req held across the first ack
        t0 = '{rw: 1'b1, addr: 30'h0000200, wd: 32'h0, g: 0, w: 0, rd: 32'h11112222};
        t1 = '{rw: 1'b1, addr: 30'h0000201, wd: 32'h0, g: 0, w: 1, rd: 32'h33334444};
        driveCore(t0);
        applyStimulus(t0, 1'b1, t1);
        applyStimulus(t1, 1'b0, none);

        // Randomized transactions, some chained back-to-back
        for (int i = 0; i < 24; i++) begin
            rq[i]     = makeTxn();
            rchain[i] = (i < 23) && ($urandom_range(0, 1) == 1);
        end
        driveCore(rq[0]);
        for (int i = 0; i < 24; i++) begin
            if (i > 0 && !rchain[i-1]) driveCore(rq[i]);
            applyStimulus(rq[i], rchain[i], (i < 23) ? rq[i+1] : none);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
